// File: rtl/hazard_sched_pkg.sv
// Shared encodings for the pipeline hazard controller: result classes, Tuse, forward codes.
// Pure definitions; no latency or backpressure of its own.
package hazard_sched_pkg;

    localparam logic [2:0] RES_NW  = 3'd0;
    localparam logic [2:0] RES_ALU = 3'd1;
    localparam logic [2:0] RES_DM  = 3'd2;
    localparam logic [2:0] RES_PC  = 3'd3;
    localparam logic [2:0] RES_MD  = 3'd4;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_W  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_E  = 2'd3;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

    typedef struct packed {
        logic [2:0] res;
        logic [4:0] a3;
    } tag_t;

    // Codes 5-7 are reserved and behave exactly like NW.
    function automatic logic res_writes(input logic [2:0] r);
        return (r == RES_ALU) || (r == RES_DM) || (r == RES_PC) || (r == RES_MD);
    endfunction

    function automatic logic res_ready_m(input logic [2:0] r);
        return (r == RES_ALU) || (r == RES_PC) || (r == RES_MD);
    endfunction

endpackage

// File: rtl/hazard_sched_if.sv
// Bundle between the datapath pipeline registers and the hazard controller.
// slave = controller side, master = datapath side.
interface hazard_sched_if;
    logic       flush;
    logic [4:0] A1_D;
    logic [4:0] A2_D;
    logic [1:0] Tuse_rs_D;
    logic [1:0] Tuse_rt_D;
    logic [2:0] Res_D;
    logic [4:0] A3_D;
    logic       md_use_D;
    logic       md_start_E;
    logic       md_div_E;

    logic [4:0] A1_E;
    logic [4:0] A2_E;
    logic [2:0] Res_E;
    logic [2:0] Res_M;
    logic [2:0] Res_W;
    logic [4:0] A3_E;
    logic [4:0] A3_M;
    logic [4:0] A3_W;
    logic       stall;
    logic       md_busy;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic [1:0] fwd_rs_E;
    logic [1:0] fwd_rt_E;
    logic       fwd_rt_M;

    modport master (
        output flush, A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, Res_D, A3_D,
               md_use_D, md_start_E, md_div_E,
        input  A1_E, A2_E, Res_E, Res_M, Res_W, A3_E, A3_M, A3_W,
               stall, md_busy, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );

    modport slave (
        input  flush, A1_D, A2_D, Tuse_rs_D, Tuse_rt_D, Res_D, A3_D,
               md_use_D, md_start_E, md_div_E,
        output A1_E, A2_E, Res_E, Res_M, Res_W, A3_E, A3_M, A3_W,
               stall, md_busy, fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M
    );
endinterface

// File: rtl/hazard_sched_md_busy_cnt.sv
// MDU busy counter: loads on start, counts down to zero; busy is registered count != 0.
// Busy rises the edge after a start; no backpressure, a start while busy simply reloads.
module hazard_sched_md_busy_cnt
    import hazard_sched_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_sched.sv
// Hazard controller: E/M/W result-tag pipeline, stall/bubble and D/E/M forward selects.
// Stall and selects are combinational off registered tags; stall freezes D and bubbles E.
module hazard_sched
    import hazard_sched_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input logic           clk,
    input logic           reset,
    hazard_sched_if.slave hs
);

    tag_t       tag_e, tag_m, tag_w, tag_d;
    logic [4:0] a1_e, a2_e, a2_m;
    logic       stall_raw;
    logic       md_busy;

    // A write to $0 is architecturally void, so it never creates a dependency.
    assign tag_d.res = (hs.A3_D == 5'd0) ? RES_NW : hs.Res_D;
    assign tag_d.a3  = hs.A3_D;

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_e <= '0;
            tag_m <= '0;
            tag_w <= '0;
            a1_e  <= '0;
            a2_e  <= '0;
            a2_m  <= '0;
        end else begin
            if (hs.flush || stall_raw) begin
                tag_e <= '0;
                a1_e  <= '0;
                a2_e  <= '0;
            end else begin
                tag_e <= tag_d;
                a1_e  <= hs.A1_D;
                a2_e  <= hs.A2_D;
            end
            if (hs.flush) begin
                tag_m <= '0;
                a2_m  <= '0;
            end else begin
                tag_m <= tag_e;
                a2_m  <= a2_e;
            end
            tag_w <= tag_m;
        end
    end

    hazard_sched_md_busy_cnt #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (hs.md_start_E),
        .is_div (hs.md_div_E),
        .busy   (md_busy)
    );

    function automatic logic src_hazard(input logic [4:0] idx, input logic [1:0] tuse,
                                        input tag_t e, input tag_t m);
        logic hit;
        hit = 1'b0;
        if (idx != 5'd0 && tuse != TUSE_NONE) begin
            if (tuse == 2'd0) begin
                hit = (idx == e.a3 && (e.res == RES_ALU || e.res == RES_DM || e.res == RES_MD))
                   || (idx == m.a3 && m.res == RES_DM);
            end else if (tuse == 2'd1) begin
                hit = (idx == e.a3 && e.res == RES_DM);
            end
        end
        return hit;
    endfunction

    // Highest stage wins; E is only a source for D-stage consumers.
    function automatic logic [1:0] fwd_sel(input logic [4:0] idx, input logic use_e,
                                           input tag_t e, input tag_t m, input tag_t w);
        logic [1:0] sel;
        sel = FWD_RF;
        if (idx != 5'd0) begin
            if (use_e && idx == e.a3 && e.res == RES_PC)
                sel = FWD_E;
            else if (idx == m.a3 && res_ready_m(m.res))
                sel = FWD_M;
            else if (idx == w.a3 && res_writes(w.res))
                sel = FWD_W;
        end
        return sel;
    endfunction

    always_comb begin
        stall_raw = src_hazard(hs.A1_D, hs.Tuse_rs_D, tag_e, tag_m)
                 || src_hazard(hs.A2_D, hs.Tuse_rt_D, tag_e, tag_m)
                 || (hs.md_use_D && (md_busy || hs.md_start_E));
    end

    assign hs.stall    = stall_raw && !hs.flush;
    assign hs.md_busy  = md_busy;

    assign hs.fwd_rs_D = fwd_sel(hs.A1_D, 1'b1, tag_e, tag_m, tag_w);
    assign hs.fwd_rt_D = fwd_sel(hs.A2_D, 1'b1, tag_e, tag_m, tag_w);
    assign hs.fwd_rs_E = fwd_sel(a1_e,    1'b0, tag_e, tag_m, tag_w);
    assign hs.fwd_rt_E = fwd_sel(a2_e,    1'b0, tag_e, tag_m, tag_w);
    assign hs.fwd_rt_M = res_writes(tag_w.res) && (tag_w.a3 != 5'd0) && (tag_w.a3 == a2_m);

    assign hs.A1_E  = a1_e;
    assign hs.A2_E  = a2_e;
    assign hs.Res_E = tag_e.res;
    assign hs.Res_M = tag_m.res;
    assign hs.Res_W = tag_w.res;
    assign hs.A3_E  = tag_e.a3;
    assign hs.A3_M  = tag_m.a3;
    assign hs.A3_W  = tag_w.a3;

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: instruction pairs with hand-derived stall/forward values.
module tb_hazard_sched;
    import hazard_sched_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_sched_if hs_if ();

    hazard_sched #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hs    (hs_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [1:0] t_rs, input logic [1:0] t_rt,
                         input logic [2:0] res, input logic [4:0] a3, input logic md);
        hs_if.A1_D      = a1;
        hs_if.A2_D      = a2;
        hs_if.Tuse_rs_D = t_rs;
        hs_if.Tuse_rt_D = t_rt;
        hs_if.Res_D     = res;
        hs_if.A3_D      = a3;
        hs_if.md_use_D  = md;
    endtask

    task automatic nop_d();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_NW, 5'd0, 1'b0);
    endtask

    task automatic drain();
        nop_d();
        hs_if.flush      = 1'b0;
        hs_if.md_start_E = 1'b0;
        hs_if.md_div_E   = 1'b0;
        repeat (3) tick();
    endtask

    // mult/div issued from E, then mflo waits in D until the counter drains.
    task automatic md_run(input logic is_div, input int n);
        set_d(5'd1, 5'd2, TUSE_NONE, TUSE_NONE, RES_NW, 5'd0, 1'b1);
        tick();
        hs_if.md_start_E = 1'b1;
        hs_if.md_div_E   = is_div;
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_MD, 5'd5, 1'b1);
        #1;
        chk("md_stall_start", hs_if.stall, 1);
        chk("md_busy_start", hs_if.md_busy, 0);
        tick();
        hs_if.md_start_E = 1'b0;
        hs_if.md_div_E   = 1'b0;
        #1;
        for (int i = 0; i < n; i++) begin
            chk("md_stall_hold", hs_if.stall, 1);
            chk("md_busy_hold", hs_if.md_busy, 1);
            tick();
        end
        chk("md_stall_release", hs_if.stall, 0);
        chk("md_busy_release", hs_if.md_busy, 0);
        drain();
    endtask

    initial begin
        reset            = 1'b1;
        hs_if.flush      = 1'b0;
        hs_if.md_start_E = 1'b0;
        hs_if.md_div_E   = 1'b0;
        nop_d();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stall", hs_if.stall, 0);
        chk("rst_res_e", hs_if.Res_E, 0);
        chk("rst_res_m", hs_if.Res_M, 0);
        chk("rst_res_w", hs_if.Res_W, 0);
        chk("rst_a3_w", hs_if.A3_W, 0);
        chk("rst_busy", hs_if.md_busy, 0);
        chk("rst_fwd_rs_d", hs_if.fwd_rs_D, 0);
        chk("rst_fwd_rt_m", hs_if.fwd_rt_M, 0);

        // lw $2 ; add $3,$2,$2 (Tuse=1)
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_DM, 5'd2, 1'b0);
        tick();
        set_d(5'd2, 5'd2, 2'd1, 2'd1, RES_ALU, 5'd3, 1'b0);
        #1;
        chk("lw_add_stall", hs_if.stall, 1);
        chk("lw_add_a3_e", hs_if.A3_E, 2);
        tick();
        chk("lw_add_bubble", hs_if.Res_E, 0);
        chk("lw_add_release", hs_if.stall, 0);
        chk("lw_add_res_m", hs_if.Res_M, RES_DM);
        tick();
        chk("lw_add_fwd_rs_e", hs_if.fwd_rs_E, FWD_W);
        chk("lw_add_fwd_rt_e", hs_if.fwd_rt_E, FWD_W);
        chk("lw_add_a1_e", hs_if.A1_E, 2);
        drain();

        // lw $2 ; beq $2,$0 (Tuse=0): two stall cycles
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_DM, 5'd2, 1'b0);
        tick();
        set_d(5'd2, 5'd0, 2'd0, 2'd0, RES_NW, 5'd0, 1'b0);
        #1;
        chk("lw_beq_stall1", hs_if.stall, 1);
        tick();
        chk("lw_beq_stall2", hs_if.stall, 1);
        tick();
        chk("lw_beq_release", hs_if.stall, 0);
        chk("lw_beq_fwd_rs_d", hs_if.fwd_rs_D, FWD_W);
        chk("lw_beq_fwd_rt_d", hs_if.fwd_rt_D, FWD_RF);
        drain();

        // jal ; jr $31
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_PC, 5'd31, 1'b0);
        tick();
        set_d(5'd31, 5'd0, 2'd0, TUSE_NONE, RES_NW, 5'd0, 1'b0);
        #1;
        chk("jal_jr_stall", hs_if.stall, 0);
        chk("jal_jr_fwd_d", hs_if.fwd_rs_D, FWD_E);
        tick();
        chk("jal_jr_fwd_e", hs_if.fwd_rs_E, FWD_M);
        drain();

        // add $4 ; beq $4,$0
        set_d(5'd1, 5'd2, 2'd1, 2'd1, RES_ALU, 5'd4, 1'b0);
        tick();
        set_d(5'd4, 5'd0, 2'd0, 2'd0, RES_NW, 5'd0, 1'b0);
        #1;
        chk("add_beq_stall", hs_if.stall, 1);
        chk("add_beq_fwd_busy", hs_if.fwd_rs_D, FWD_RF);
        tick();
        chk("add_beq_release", hs_if.stall, 0);
        chk("add_beq_fwd_m", hs_if.fwd_rs_D, FWD_M);
        drain();

        // add with destination $0 is demoted to NW
        set_d(5'd1, 5'd2, 2'd1, 2'd1, RES_ALU, 5'd0, 1'b0);
        tick();
        set_d(5'd0, 5'd0, 2'd0, 2'd0, RES_NW, 5'd0, 1'b0);
        #1;
        chk("a3zero_res_e", hs_if.Res_E, RES_NW);
        chk("a3zero_stall", hs_if.stall, 0);
        drain();

        md_run(1'b1, 10);
        md_run(1'b0, 5);

        // lw $4 ; sw $4: store data taken from W while sw is in M
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_DM, 5'd4, 1'b0);
        tick();
        set_d(5'd0, 5'd4, TUSE_NONE, TUSE_NONE, RES_NW, 5'd0, 1'b0);
        #1;
        chk("sw_stall", hs_if.stall, 0);
        tick();
        chk("sw_fwd_rt_e", hs_if.fwd_rt_E, FWD_RF);
        chk("sw_fwd_rt_m_early", hs_if.fwd_rt_M, 0);
        nop_d();
        tick();
        chk("sw_fwd_rt_m", hs_if.fwd_rt_M, 1);
        drain();

        // flush while a load-use stall is pending
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_DM, 5'd2, 1'b0);
        tick();
        set_d(5'd2, 5'd2, 2'd1, 2'd1, RES_ALU, 5'd3, 1'b0);
        #1;
        chk("flush_pre_stall", hs_if.stall, 1);
        hs_if.flush = 1'b1;
        #1;
        chk("flush_masks_stall", hs_if.stall, 0);
        tick();
        hs_if.flush = 1'b0;
        #1;
        chk("flush_res_e", hs_if.Res_E, 0);
        chk("flush_res_m", hs_if.Res_M, 0);
        chk("flush_stall_after", hs_if.stall, 0);
        drain();

        // synchronous reset in the middle of a divide
        set_d(5'd1, 5'd2, TUSE_NONE, TUSE_NONE, RES_ALU, 5'd6, 1'b0);
        tick();
        nop_d();
        hs_if.md_start_E = 1'b1;
        hs_if.md_div_E   = 1'b1;
        tick();
        hs_if.md_start_E = 1'b0;
        hs_if.md_div_E   = 1'b0;
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, RES_MD, 5'd5, 1'b1);
        #1;
        chk("rstmid_busy_before", hs_if.md_busy, 1);
        chk("rstmid_a3_m_before", hs_if.A3_M, 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstmid_busy", hs_if.md_busy, 0);
        chk("rstmid_stall", hs_if.stall, 0);
        chk("rstmid_res_m", hs_if.Res_M, 0);
        chk("rstmid_res_w", hs_if.Res_W, 0);
        chk("rstmid_a3_w", hs_if.A3_W, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
